// File: rtl/active_list.sv
// Reorder buffer: 32-entry circular active list with in-order commit and
// mispredict rollback that undoes squashed entries youngest-first.
module active_list (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alloc_valid,
    input  logic        alloc_uses_rw,
    input  logic [4:0]  alloc_rw_arch,
    input  logic [5:0]  alloc_rw_phys,
    input  logic [5:0]  alloc_old_phys,
    input  logic [31:0] alloc_id,
    output logic        alloc_ready,
    output logic [4:0]  alloc_index,
    input  logic        complete_valid,
    input  logic [4:0]  complete_index,
    input  logic        complete_mispredict,
    output logic        commit_valid,
    output logic        commit_uses_rw,
    output logic [4:0]  commit_rw_arch,
    output logic [5:0]  commit_rw_phys,
    output logic [5:0]  commit_old_phys,
    output logic        rollback_valid,
    output logic        rollback_uses_rw,
    output logic [4:0]  rollback_rw_arch,
    output logic [5:0]  rollback_old_phys,
    output logic [5:0]  rollback_rw_phys,
    output logic        flush_busy,
    output logic        flush_done,
    output logic [31:0] flushed_instruction_ID
);

    typedef enum logic {StNormal, StFlush} state_e;

    state_e      state_q;
    logic [4:0]  head_q, tail_q, branch_q;
    logic [5:0]  count_q;
    logic [31:0] done_q;
    logic [31:0] flush_id_q;

    logic        uses_mem [32];
    logic [4:0]  arch_mem [32];
    logic [5:0]  phys_mem [32];
    logic [5:0]  old_mem  [32];
    logic [31:0] id_mem   [32];

    logic       in_normal, do_alloc, comp_live, at_branch;
    logic [4:0] tail_m1, comp_off;

    always_comb begin
        in_normal = (state_q == StNormal);
        tail_m1   = tail_q - 5'd1;
        comp_off  = complete_index - head_q;
        // Offset from head below count means the index lies in head..tail-1.
        comp_live = ({1'b0, comp_off} < count_q);
        at_branch = (tail_m1 == branch_q);

        alloc_ready  = in_normal & (count_q != 6'd32) & ~(complete_valid & complete_mispredict);
        do_alloc     = alloc_valid & alloc_ready;
        alloc_index  = tail_q;
        commit_valid = in_normal & (count_q != 6'd0) & done_q[head_q];

        commit_uses_rw  = uses_mem[head_q];
        commit_rw_arch  = arch_mem[head_q];
        commit_rw_phys  = phys_mem[head_q];
        commit_old_phys = old_mem[head_q];

        rollback_valid    = ~in_normal & ~at_branch;
        rollback_uses_rw  = uses_mem[tail_m1];
        rollback_rw_arch  = arch_mem[tail_m1];
        rollback_old_phys = old_mem[tail_m1];
        rollback_rw_phys  = phys_mem[tail_m1];

        flush_busy             = ~in_normal;
        flush_done             = ~in_normal & at_branch;
        flushed_instruction_ID = flush_id_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StNormal;
            head_q     <= 5'd0;
            tail_q     <= 5'd0;
            branch_q   <= 5'd0;
            count_q    <= 6'd0;
            done_q     <= 32'd0;
            flush_id_q <= 32'd0;
        end else begin
            case (state_q)
                StNormal: begin
                    if (do_alloc) begin
                        done_q[tail_q] <= 1'b0;
                        tail_q         <= tail_q + 5'd1;
                    end
                    if (complete_valid && comp_live) begin
                        done_q[complete_index] <= 1'b1;
                        if (complete_mispredict) begin
                            branch_q   <= complete_index;
                            flush_id_q <= id_mem[complete_index];
                            state_q    <= StFlush;
                        end
                    end
                    if (commit_valid) begin
                        head_q <= head_q + 5'd1;
                    end
                    count_q <= count_q + {5'd0, do_alloc} - {5'd0, commit_valid};
                end
                StFlush: begin
                    if (!at_branch) begin
                        tail_q  <= tail_m1;
                        count_q <= count_q - 6'd1;
                    end else begin
                        state_q <= StNormal;
                    end
                end
                default: state_q <= StNormal;
            endcase
        end
    end

    // Payload storage needs no reset; done bits and count guard its validity.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            uses_mem[tail_q] <= alloc_uses_rw;
            arch_mem[tail_q] <= alloc_rw_arch;
            phys_mem[tail_q] <= alloc_rw_phys;
            old_mem[tail_q]  <= alloc_old_phys;
            id_mem[tail_q]   <= alloc_id;
        end
    end

endmodule

// File: tb/tb_active_list.sv
// Randomized and directed bench for active_list against a queue-based model.
module tb_active_list;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid, alloc_uses_rw;
    logic [4:0]  alloc_rw_arch;
    logic [5:0]  alloc_rw_phys, alloc_old_phys;
    logic [31:0] alloc_id;
    logic        alloc_ready;
    logic [4:0]  alloc_index;
    logic        complete_valid, complete_mispredict;
    logic [4:0]  complete_index;
    logic        commit_valid, commit_uses_rw;
    logic [4:0]  commit_rw_arch;
    logic [5:0]  commit_rw_phys, commit_old_phys;
    logic        rollback_valid, rollback_uses_rw;
    logic [4:0]  rollback_rw_arch;
    logic [5:0]  rollback_old_phys, rollback_rw_phys;
    logic        flush_busy, flush_done;
    logic [31:0] flushed_instruction_ID;

    always #5 clk = ~clk;

    active_list dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .alloc_valid            (alloc_valid),
        .alloc_uses_rw          (alloc_uses_rw),
        .alloc_rw_arch          (alloc_rw_arch),
        .alloc_rw_phys          (alloc_rw_phys),
        .alloc_old_phys         (alloc_old_phys),
        .alloc_id               (alloc_id),
        .alloc_ready            (alloc_ready),
        .alloc_index            (alloc_index),
        .complete_valid         (complete_valid),
        .complete_index         (complete_index),
        .complete_mispredict    (complete_mispredict),
        .commit_valid           (commit_valid),
        .commit_uses_rw         (commit_uses_rw),
        .commit_rw_arch         (commit_rw_arch),
        .commit_rw_phys         (commit_rw_phys),
        .commit_old_phys        (commit_old_phys),
        .rollback_valid         (rollback_valid),
        .rollback_uses_rw       (rollback_uses_rw),
        .rollback_rw_arch       (rollback_rw_arch),
        .rollback_old_phys      (rollback_old_phys),
        .rollback_rw_phys       (rollback_rw_phys),
        .flush_busy             (flush_busy),
        .flush_done             (flush_done),
        .flushed_instruction_ID (flushed_instruction_ID)
    );

    typedef struct {
        int          idx;
        bit          uses;
        bit [4:0]    arch;
        bit [5:0]    phys;
        bit [5:0]    old;
        bit [31:0]   id;
        bit          done;
    } ent_t;

    // Model: queue front is the oldest instruction.
    ent_t      q[$];
    int        m_tail;
    bit        m_flush;
    int        m_b;
    bit [31:0] m_fid;

    int total = 0;
    int bad   = 0;
    int rb_seen;
    int fd_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tail  = 0;
        m_flush = 0;
        m_b     = 0;
        m_fid   = 0;
    endtask

    task automatic idle();
        alloc_valid         = 1'b0;
        complete_valid      = 1'b0;
        complete_mispredict = 1'b0;
        complete_index      = 5'd0;
    endtask

    task automatic set_alloc(input bit v, input bit [31:0] id);
        alloc_valid    = v;
        alloc_uses_rw  = 1'($urandom);
        alloc_rw_arch  = 5'($urandom);
        alloc_rw_phys  = 6'($urandom);
        alloc_old_phys = 6'($urandom);
        alloc_id       = id;
    endtask

    task automatic set_complete(input bit v, input int idx, input bit mp);
        complete_valid      = v;
        complete_index      = 5'(idx);
        complete_mispredict = mp;
    endtask

    // One cycle: check outputs against the model, then advance the model.
    task automatic step();
        bit   e_ready, e_commit, e_rb, e_fd;
        int   pos;
        ent_t n;
        @(negedge clk);
        e_ready  = !m_flush && q.size() < 32 && !(complete_valid && complete_mispredict);
        e_commit = !m_flush && q.size() > 0 && q[0].done;
        e_rb     = m_flush && q.size() > 0 && q[$].idx != m_b;
        e_fd     = m_flush && q.size() > 0 && q[$].idx == m_b;
        check_eq("alloc_ready", 32'(alloc_ready), 32'(e_ready));
        check_eq("alloc_index", 32'(alloc_index), 32'(m_tail));
        check_eq("commit_valid", 32'(commit_valid), 32'(e_commit));
        if (e_commit) begin
            check_eq("commit_uses_rw", 32'(commit_uses_rw), 32'(q[0].uses));
            check_eq("commit_rw_arch", 32'(commit_rw_arch), 32'(q[0].arch));
            check_eq("commit_rw_phys", 32'(commit_rw_phys), 32'(q[0].phys));
            check_eq("commit_old_phys", 32'(commit_old_phys), 32'(q[0].old));
        end
        check_eq("rollback_valid", 32'(rollback_valid), 32'(e_rb));
        if (e_rb) begin
            rb_seen++;
            check_eq("rollback_uses_rw", 32'(rollback_uses_rw), 32'(q[$].uses));
            check_eq("rollback_rw_arch", 32'(rollback_rw_arch), 32'(q[$].arch));
            check_eq("rollback_rw_phys", 32'(rollback_rw_phys), 32'(q[$].phys));
            check_eq("rollback_old_phys", 32'(rollback_old_phys), 32'(q[$].old));
        end
        if (e_fd) fd_seen++;
        check_eq("flush_busy", 32'(flush_busy), 32'(m_flush));
        check_eq("flush_done", 32'(flush_done), 32'(e_fd));
        check_eq("flushed_id", flushed_instruction_ID, m_fid);

        if (!rst_n) begin
            model_reset();
        end else if (m_flush) begin
            if (e_rb) begin
                void'(q.pop_back());
                m_tail = (m_tail + 31) % 32;
            end else begin
                m_flush = 0;
            end
        end else begin
            pos = -1;
            foreach (q[i]) if (q[i].idx == int'(complete_index)) pos = i;
            if (complete_valid && pos >= 0) begin
                q[pos].done = 1;
                if (complete_mispredict) begin
                    m_flush = 1;
                    m_b     = int'(complete_index);
                    m_fid   = q[pos].id;
                end
            end
            if (e_commit) void'(q.pop_front());
            if (alloc_valid && e_ready) begin
                n.idx  = m_tail;
                n.uses = alloc_uses_rw;
                n.arch = alloc_rw_arch;
                n.phys = alloc_rw_phys;
                n.old  = alloc_old_phys;
                n.id   = alloc_id;
                n.done = 0;
                q.push_back(n);
                m_tail = (m_tail + 1) % 32;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int nd[$];
        int p;
        bit live;
        rb_seen = 0;
        fd_seen = 0;
        rst_n = 1'b0;
        idle();
        set_alloc(0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // In-order commit despite out-of-order completion.
        for (int i = 0; i < 4; i++) begin
            idle(); set_alloc(1, 32'(i)); step();
        end
        idle();
        set_complete(1, 2, 0); step();
        set_complete(1, 0, 0); step();
        set_complete(1, 1, 0); step();
        set_complete(1, 3, 0); step();
        drain(4);

        // Fill to 32, then free one slot.
        do_reset();
        for (int i = 0; i < 33; i++) begin
            idle(); set_alloc(1, 32'(100 + i)); step();
        end
        idle(); set_alloc(1, 32'hAA); set_complete(1, 0, 0); step();
        idle(); set_alloc(1, 32'hAB); step();
        set_alloc(1, 32'hAC); step();

        // Mispredict mid-list: three rollbacks then flush_done.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle(); set_alloc(1, 32'(200 + i)); step();
        end
        rb_seen = 0; fd_seen = 0;
        idle(); set_complete(1, 2, 1); step();
        drain(6);
        check_eq("rb_count_mid", 32'(rb_seen), 32'd3);
        check_eq("fd_count_mid", 32'(fd_seen), 32'd1);
        check_eq("tail_after_flush", 32'(alloc_index), 32'd3);
        check_eq("flush_id_mid", flushed_instruction_ID, 32'd202);

        // Mispredict on youngest: no rollback.
        rb_seen = 0; fd_seen = 0;
        idle(); set_alloc(1, 32'h55); step();
        idle(); set_complete(1, 3, 1); step();
        drain(3);
        check_eq("rb_count_young", 32'(rb_seen), 32'd0);
        check_eq("fd_count_young", 32'(fd_seen), 32'd1);

        // Move head to 30, allocate across wrap, mispredict at 31.
        do_reset();
        for (int i = 0; i < 31; i++) begin
            idle(); set_alloc(i < 30, 32'(300 + i));
            if (i > 0) set_complete(1, i - 1, 0);
            step();
        end
        drain(2);
        for (int i = 0; i < 4; i++) begin
            idle(); set_alloc(1, 32'(400 + i)); step();
        end
        rb_seen = 0;
        idle(); set_complete(1, 31, 1); step();
        drain(4);
        check_eq("rb_count_wrap", 32'(rb_seen), 32'd2);
        check_eq("tail_after_wrap", 32'(alloc_index), 32'd0);

        // Reset in the middle of a flush.
        for (int i = 0; i < 5; i++) begin
            idle(); set_alloc(1, 32'(500 + i)); step();
        end
        idle(); set_complete(1, 1, 1); step();
        step();
        do_reset();
        drain(2);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            idle();
            set_alloc($urandom % 4 != 0, $urandom);
            if ($urandom % 300 == 0) rst_n = 1'b0;
            nd.delete();
            foreach (q[i]) if (!q[i].done) nd.push_back(i);
            if ($urandom % 3 != 0 && nd.size() > 0) begin
                p = nd[$urandom % nd.size()];
                set_complete($urandom % 2, q[p].idx, $urandom % 8 == 0);
            end else begin
                p = int'($urandom % 32);
                live = 0;
                foreach (q[i]) if (q[i].idx == p) live = 1;
                set_complete($urandom % 2, p, live ? 1'b0 : 1'($urandom));
            end
            step();
            rst_n = 1'b1;
        end
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
